// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Operands registered before the ALU, result registered after it.
package alu_pkg;
    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sub  = 4'd1,
        alu_sll  = 4'd2,
        alu_slt  = 4'd3,
        alu_sltu = 4'd4,
        alu_xor  = 4'd5,
        alu_srl  = 4'd6,
        alu_sra  = 4'd7,
        alu_or   = 4'd8,
        alu_and  = 4'd9
    } aluop_t;
endpackage

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rd,
    output logic             zero
);
    import alu_pkg::*;

    // Shift amounts use the full rs2 value, so large shifts saturate.
    always_comb begin
        rd = '0;
        case (op)
            alu_add:  rd = a + b;
            alu_sub:  rd = a - b;
            alu_sll:  rd = a << b;
            alu_slt:  rd = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            alu_sltu: rd = {{(WIDTH-1){1'b0}}, (a < b)};
            alu_xor:  rd = a ^ b;
            alu_srl:  rd = a >> b;
            alu_sra:  rd = $signed(a) >>> b;
            alu_or:   rd = a | b;
            alu_and:  rd = a & b;
            default:  rd = '0;
        endcase
    end

    assign zero = (rd == '0);
endmodule

module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NREQ-1:0]       req_valid_in,
    output logic [NREQ-1:0]       req_ready_out,
    input  logic [NREQ*4-1:0]     req_op_in,
    input  logic [NREQ*WIDTH-1:0] req_a_in,
    input  logic [NREQ*WIDTH-1:0] req_b_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [IDW-1:0]        rsp_id_out,
    output logic [WIDTH-1:0]      rsp_data_out,
    output logic                  rsp_zero_out,
    output logic                  busy_out
);
    import alu_pkg::*;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, ptr_nx;
    logic [IDW-1:0]   gnt, tag;
    logic             any_valid;
    logic             accept;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] alu_rd;
    logic             alu_zero;

    // Scan from ptr downward in priority; last hit wins, i.e. nearest to ptr.
    always_comb begin
        int j;
        gnt       = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req_valid_in[j]) begin
                gnt       = IDW'(j);
                any_valid = 1'b1;
            end
        end
    end

    assign accept        = (state == IDLE) && !rst_in && any_valid;
    assign req_ready_out = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt) : '0;
    assign busy_out      = (state != IDLE);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = EXEC;
                    ptr_nx   = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
                end
            end
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready_in) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            op_q          <= alu_add;
            a_q           <= '0;
            b_q           <= '0;
            tag           <= '0;
            rsp_valid_out <= 1'b0;
            rsp_id_out    <= '0;
            rsp_data_out  <= '0;
            rsp_zero_out  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_op_in[4*gnt +: 4];
                a_q  <= req_a_in[WIDTH*gnt +: WIDTH];
                b_q  <= req_b_in[WIDTH*gnt +: WIDTH];
                tag  <= gnt;
            end
            if (state == EXEC) begin
                rsp_valid_out <= 1'b1;
                rsp_data_out  <= alu_rd;
                rsp_zero_out  <= alu_zero;
                rsp_id_out    <= tag;
            end else if (state == RESP && rsp_ready_in) begin
                rsp_valid_out <= 1'b0;
            end
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .rd   (alu_rd),
        .zero (alu_zero)
    );
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with three requesters.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int NREQ  = 3;
    localparam int IDW   = 3;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*4-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_zero;
    logic                  busy;

    int total = 0;
    int passed = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_op_in     (req_op),
        .req_a_in      (req_a),
        .req_b_in      (req_b),
        .rsp_valid_out (rsp_valid),
        .rsp_ready_in  (rsp_ready),
        .rsp_id_out    (rsp_id),
        .rsp_data_out  (rsp_data),
        .rsp_zero_out  (rsp_zero),
        .busy_out      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_op[4*i +: 4]         = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_op(input int idx, input logic [3:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] d, output logic z,
                          output logic [IDW-1:0] id, output logic to);
        int n;
        set_req(idx, op, a, b);
        req_valid = NREQ'(1) << idx;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 10) begin tick(); n++; end
        to = !req_ready[idx];
        tick();
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        to = to | !rsp_valid;
        d  = rsp_data;
        z  = rsp_zero;
        id = rsp_id;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, alu_add, 32'(i), 32'd1);
        #1;
        total++;
        if (req_ready !== 3'b000) $display("FAIL rst_cycle_ready got=%b exp=000", req_ready);
        else passed++;
        tick();
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
        else passed++;
        total++;
        if (rsp_data !== 32'd0 || rsp_id !== 3'd0 || rsp_zero !== 1'b0)
            $display("FAIL rst_rsp_fields got=%h/%0d/%b exp=0/0/0", rsp_data, rsp_id, rsp_zero);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 3'b001) $display("FAIL rst_ptr_zero got=%b exp=001", req_ready);
        else passed++;
        req_valid = '0;
        #1;
        total++;
        if (req_ready !== 3'b000) $display("FAIL idle_no_valid got=%b exp=000", req_ready);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        set_req(0, alu_sub, 32'd5, 32'd5);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd0)
            $display("FAIL mid_resp_pre got=%b/%h exp=1/0", rsp_valid, rsp_data);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_resp_dropped got=%b/%b exp=0/0", rsp_valid, busy);
        else passed++;
        req_valid = 3'b011;
        #1;
        total++;
        if (req_ready !== 3'b001) $display("FAIL mid_resp_ptr got=%b exp=001", req_ready);
        else passed++;
        set_req(1, alu_add, 32'd7, 32'd8);
        req_valid = 3'b010;
        #1;
        total++;
        if (req_ready !== 3'b010) $display("FAIL mid_resp_req1 got=%b exp=010", req_ready);
        else passed++;
        tick();
        req_valid = '0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd1 || rsp_data !== 32'd15)
            $display("FAIL mid_resp_req1_rsp got=%b/%0d/%0d exp=1/1/15",
                     rsp_valid, rsp_id, rsp_data);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_single_latency();
        do_reset();
        set_req(0, alu_add, 32'hFFFF_FFFF, 32'd1);
        req_valid = 3'b001;
        #1;
        total++;
        if (req_ready !== 3'b001) $display("FAIL lat_accept got=%b exp=001", req_ready);
        else passed++;
        tick();
        req_valid = '0;
        total++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL lat_exec got=%b/%b exp=1/0", busy, rsp_valid);
        else passed++;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 3'd0)
            $display("FAIL lat_resp got=%b/%h/%b/%0d exp=1/0/1/0",
                     rsp_valid, rsp_data, rsp_zero, rsp_id);
        else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL lat_idle got=%b/%b exp=0/0", rsp_valid, busy);
        else passed++;
    endtask

    task automatic test_round_robin();
        int exp_id[4]   = '{0, 1, 2, 0};
        int exp_data[4] = '{10, 11, 12, 10};
        int cnt = 0;
        int budget = 0;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, alu_add, 32'(i), 32'd10);
        rsp_ready = 1'b1;
        req_valid = '1;
        while (cnt < 4 && budget < 40) begin
            tick();
            budget++;
            if (rsp_valid) begin
                total++;
                if (rsp_id !== IDW'(exp_id[cnt]) || rsp_data !== 32'(exp_data[cnt]))
                    $display("FAIL rr_resp%0d got=%0d/%0d exp=%0d/%0d",
                             cnt, rsp_id, rsp_data, exp_id[cnt], exp_data[cnt]);
                else passed++;
                cnt++;
            end
        end
        req_valid = '0;
        total++;
        if (cnt != 4) $display("FAIL rr_timeout got=%0d exp=4 responses", cnt);
        else passed++;
        tick();
        tick();
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        do_reset();
        set_req(1, alu_slt, 32'h8000_0000, 32'd1);
        set_req(0, alu_xor, 32'h0000_00F0, 32'h0000_00FF);
        req_valid = 3'b010;
        tick();
        req_valid = 3'b011;
        tick();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd1 || rsp_id !== 3'd1 ||
                rsp_zero !== 1'b0 || req_ready !== 3'b000)
                $display("FAIL bp_hold%0d got=%b/%h/%0d/%b/%b exp=1/1/1/0/000",
                         c, rsp_valid, rsp_data, rsp_id, rsp_zero, req_ready);
            else passed++;
            if (c < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 3'b001)
            $display("FAIL bp_release got=%b/%b exp=0/001", rsp_valid, req_ready);
        else passed++;
        tick();
        req_valid = '0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== 32'h0000_000F)
            $display("FAIL bp_req0 got=%b/%0d/%h exp=1/0/0000000f",
                     rsp_valid, rsp_id, rsp_data);
        else passed++;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_shift_edges();
        logic [3:0]       ops[7];
        logic [WIDTH-1:0] as[7];
        logic [WIDTH-1:0] bs[7];
        logic [WIDTH-1:0] ed[7];
        logic             ez[7];
        logic [WIDTH-1:0] d;
        logic             z;
        logic [IDW-1:0]   id;
        logic             to;
        ops = '{alu_sra, alu_sll, alu_srl, alu_sra, 4'hF, alu_sltu, alu_sub};
        as  = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'h8000_0000,
                32'd5, 32'd1, 32'd3};
        bs  = '{32'd31, 32'd32, 32'd31, 32'd40, 32'd3, 32'h8000_0000, 32'd5};
        ed  = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1,
                32'hFFFF_FFFE};
        ez  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            run_op(k % NREQ, ops[k], as[k], bs[k], d, z, id, to);
            total++;
            if (to || d !== ed[k] || z !== ez[k] || id !== IDW'(k % NREQ))
                $display("FAIL alu_case%0d got=%h/%b/%0d to=%b exp=%h/%b/%0d",
                         k, d, z, id, to, ed[k], ez[k], k % NREQ);
            else passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_reset_mid_resp();
        test_single_latency();
        test_round_robin();
        test_back_pressure();
        test_shift_edges();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one instance of the team's combinational ALU (`alu`, `aluop_t` control) between NREQ independent requesters, for example the main pipeline, the address generator and a debug port.
- Arbitration is round-robin with a per-requester valid/ready request handshake.
- Operands and op are registered before the ALU, and the result is registered after it. The result returns tagged with the requester index over a valid/ready response handshake.
- A three-state sequencer (IDLE, EXEC, RESP) controls the block; one operation is in flight at a time.

Parameters:
- WIDTH, 32, ALU operand and result width (passed to the `alu` instance).
- NREQ, 2, number of requesters; legal range 2..8.
- IDW, 3, width of the requester tag; must satisfy 2**IDW >= NREQ.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- req_valid_in  input  NREQ  bit i: requester i presents an operation.
- req_ready_out  output  NREQ  bit i: operation i accepted this cycle (one-hot or zero).
- req_op_in  input  NREQ*4  `aluop_t` encoding per requester; slice i is [4*i+3:4*i].
- req_a_in  input  NREQ*WIDTH  rs1 operand per requester; slice i.
- req_b_in  input  NREQ*WIDTH  rs2 operand per requester; slice i.
- rsp_valid_out  output  1  result available.
- rsp_ready_in  input  1  consumer accepts the result.
- rsp_id_out  output  IDW  index of the requester that owns the result.
- rsp_data_out  output  WIDTH  ALU rd result.
- rsp_zero_out  output  1  ALU zero flag for this result.
- busy_out  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_in high at a clock edge, from any state):
  - state=IDLE, round-robin pointer ptr=0.
  - rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, rsp_zero_out=0, busy_out=0, req_ready_out=0.
  - Operand/op registers are cleared to 0, op to `alu_add`.
  - Any in-flight operation is dropped with no response.
  - The reset cycle itself accepts nothing.
- Grant (combinational, IDLE only):
  - g is the first i with req_valid_in[i]=1, scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - req_ready_out is one-hot at bit g when state=IDLE, not in reset, and any valid is high; otherwise it is all zero.
  - Requesters must hold valid, op and operands stable until ready; valid must not depend on ready.
- IDLE:
  - On accept: latch op, a and b from slice g; latch tag=g; set ptr=(g+1) mod NREQ; go to EXEC.
  - With no valid request, stay in IDLE and leave ptr unchanged.
- EXEC (exactly one cycle):
  - The ALU sees the registered op and operands.
  - At the edge, rd goes to rsp_data_out, zero to rsp_zero_out and tag to rsp_id_out; rsp_valid_out goes to 1; go to RESP.
- RESP:
  - rsp_valid_out=1, and all rsp_* outputs are held stable until rsp_ready_in=1 at an edge.
  - On that edge: rsp_valid_out goes to 0 and state goes to IDLE.
  - No new request is accepted in RESP, including the handshake cycle itself.
- Latency and throughput:
  - Accept at edge T gives rsp_valid_out=1 from T+2.
  - Minimum spacing between accepts is 3 cycles.
  - Back-pressure on rsp_ready_in stalls arbitration indefinitely.
- Arithmetic:
  - Identical to the shared ALU: modulo 2^WIDTH add/sub; slt is signed, sltu unsigned; sra is arithmetic.
  - Shifts use the full rs2 value unmasked, so rs2 >= WIDTH yields 0 for sll/srl and the sign fill for sra.
  - An undefined op returns 0 with zero=1.
- Boundaries:
  - ptr wraps from NREQ-1 to 0.
  - When all requesters are valid continuously, grants rotate 0,1,…,NREQ-1,0.
  - A single continuously valid requester is granted on every IDLE visit.
  - A requester dropping valid before being granted is legal and loses nothing.
  - rsp_ready_in held high before rsp_valid_out rises has no effect until RESP.

Test Plan:
- Reset mid-RESP: req0 sub a=5,b=5, hold rsp_ready_in=0, assert rst_in for 1 cycle → next cycle rsp_valid_out=0, busy_out=0, ptr=0; a subsequent req1 is granted.
- Single op latency: req0 add a=0xFFFFFFFF, b=1 accepted at T → rsp_valid_out=1 at T+2 with data=0, zero=1, id=0; rsp_ready_in=1 returns to IDLE at T+3.
- Round-robin fairness: NREQ=3, all valid continuously, ops add a=i,b=10 → responses in id order 0,1,2,0 with data 10,11,12,10.
- Back-pressure: req1 slt a=0x80000000, b=1, rsp_ready_in low 5 cycles → data=1, id=1 held stable all 5 cycles; req0 valid throughout gets ready only after the response handshake.
- Shift edge cases: sra a=0x80000000, b=31 → 0xFFFFFFFF, zero=0; sll a=1, b=32 → 0, zero=1.
